// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared state encodings and timing defaults for the flash ROM read path
package rom_pkg;

  localparam int ROM_WIDTH_DEF     = 16;
  localparam int ROM_ADDR_DEF      = 24;
  localparam int ACCESS_CYCLES_DEF = 8;
  localparam int RST_CYCLES_DEF    = 32;
  localparam int RECOV_CYCLES_DEF  = 16;

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_RST_RECOV = 3'd1,
    ST_IDLE      = 3'd2,
    ST_ACCESS    = 3'd3,
    ST_CAPTURE   = 3'd4
  } flash_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flash_timer.sv
// rtl/flash_timer.sv - loadable down-counter; done is high for the single cycle the count sits at 0
module flash_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;

  // No reset port: the controller holds start_i high for as long as its reset is asserted.
  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    if (start_i) begin
      count_d = load_val_i;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (count_q == '0) begin
        busy_d = 1'b0;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
    busy_q  <= busy_d;
  end

  assign done_o = busy_q && (count_q == '0);

endmodule

// File: rtl/flash_rom_controller.sv
// rtl/flash_rom_controller.sv - timed asynchronous x16 NOR flash reads with power-up reset sequencing
module flash_rom_controller
  import rom_pkg::*;
#(
  parameter int WIDTH         = ROM_WIDTH_DEF,
  parameter int ROM_ADDR      = ROM_ADDR_DEF,
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int RECOV_CYCLES  = RECOV_CYCLES_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ROM_ADDR-1:0] addr_i,
  input  logic                load_i,
  input  logic                byte_i,
  output logic [WIDTH-1:0]    data_o,
  output logic                ready_o,
  output logic [ROM_ADDR-2:0] flash_addr_o,
  input  logic [WIDTH-1:0]    flash_dq_i,
  output logic                flash_ce_n_o,
  output logic                flash_oe_n_o,
  output logic                flash_we_n_o,
  output logic                flash_byte_n_o,
  output logic                flash_rst_n_o
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, RECOV_CYCLES, ACCESS_CYCLES) + 1);
  // A load of L gives L+1 cycles to done; reset and recovery loads are trimmed so the
  // visible durations are exactly RST_CYCLES and RECOV_CYCLES, while an access keeps
  // CE/OE low for ACCESS_CYCLES plus the sampling cycle.
  localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_RECOV  = CNT_W'(RECOV_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_ACCESS = CNT_W'(ACCESS_CYCLES);

  flash_state_e        state_q, state_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    dq_q, dq_d;
  logic                ready_q, ready_d;
  logic [ROM_ADDR-2:0] flash_addr_q, flash_addr_d;
  logic                ce_oe_n_q, ce_oe_n_d;
  logic                flash_rst_n_q, flash_rst_n_d;
  logic                byte_q, byte_d;
  logic                lsb_q, lsb_d;
  logic                tmr_start;
  logic [CNT_W-1:0]    tmr_load;
  logic                tmr_done;
  logic [7:0]          sel_byte;

  flash_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .start_i   (tmr_start),
    .load_val_i(tmr_load),
    .done_o    (tmr_done)
  );

  assign sel_byte = lsb_q ? dq_q[15:8] : dq_q[7:0];

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    dq_d          = dq_q;
    ready_d       = ready_q;
    flash_addr_d  = flash_addr_q;
    ce_oe_n_d     = ce_oe_n_q;
    flash_rst_n_d = flash_rst_n_q;
    byte_d        = byte_q;
    lsb_d         = lsb_q;
    tmr_start     = 1'b0;
    tmr_load      = '0;

    case (state_q)
      ST_RST_HOLD: begin
        if (tmr_done) begin
          flash_rst_n_d = 1'b1;
          tmr_start     = 1'b1;
          tmr_load      = LD_RECOV;
          state_d       = ST_RST_RECOV;
        end
      end
      ST_RST_RECOV: begin
        if (tmr_done) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (load_i) begin
          flash_addr_d = addr_i[ROM_ADDR-1:1];
          byte_d       = byte_i;
          lsb_d        = addr_i[0];
          ready_d      = 1'b0;
          ce_oe_n_d    = 1'b0;
          tmr_start    = 1'b1;
          tmr_load     = LD_ACCESS;
          state_d      = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // DQ is sampled while OE is still low; CE/OE release on the same edge.
        if (tmr_done) begin
          dq_d      = flash_dq_i;
          ce_oe_n_d = 1'b1;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        data_d  = byte_q ? {{(WIDTH-8){1'b0}}, sel_byte} : dq_q;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_RST_HOLD;
      end
    endcase

    if (rst_i) begin
      tmr_start = 1'b1;
      tmr_load  = LD_RST;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RST_HOLD;
      data_q        <= '0;
      dq_q          <= '0;
      ready_q       <= 1'b0;
      flash_addr_q  <= '0;
      ce_oe_n_q     <= 1'b1;
      flash_rst_n_q <= 1'b0;
      byte_q        <= 1'b0;
      lsb_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      dq_q          <= dq_d;
      ready_q       <= ready_d;
      flash_addr_q  <= flash_addr_d;
      ce_oe_n_q     <= ce_oe_n_d;
      flash_rst_n_q <= flash_rst_n_d;
      byte_q        <= byte_d;
      lsb_q         <= lsb_d;
    end
  end

  assign data_o         = data_q;
  assign ready_o        = ready_q;
  assign flash_addr_o   = flash_addr_q;
  assign flash_ce_n_o   = ce_oe_n_q;
  assign flash_oe_n_o   = ce_oe_n_q;
  assign flash_we_n_o   = 1'b1;
  assign flash_byte_n_o = 1'b1;
  assign flash_rst_n_o  = flash_rst_n_q;

endmodule

// File: tb/tb_flash_rom_controller.sv
// tb/tb_flash_rom_controller.sv - directed bench with a cycle-level behavioural model and flash memory model
module tb_flash_rom_controller;
  import rom_pkg::*;

  localparam int ACC = ACCESS_CYCLES_DEF;
  localparam int RSTC = RST_CYCLES_DEF;
  localparam int REC = RECOV_CYCLES_DEF;

  logic        clk;
  logic        rst;
  logic [23:0] addr;
  logic        load;
  logic        byte_sel;
  logic [15:0] data;
  logic        ready;
  logic [22:0] faddr;
  logic [15:0] dq;
  logic        ce_n, oe_n, we_n, byte_n, frst_n;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] mem [int];

  function automatic logic [15:0] word_at(input logic [22:0] a);
    int key;
    key = int'(a);
    if (mem.exists(key)) return mem[key];
    return a[15:0] ^ 16'hA5A5;
  endfunction

  flash_rom_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .addr_i        (addr),
    .load_i        (load),
    .byte_i        (byte_sel),
    .data_o        (data),
    .ready_o       (ready),
    .flash_addr_o  (faddr),
    .flash_dq_i    (dq),
    .flash_ce_n_o  (ce_n),
    .flash_oe_n_o  (oe_n),
    .flash_we_n_o  (we_n),
    .flash_byte_n_o(byte_n),
    .flash_rst_n_o (frst_n)
  );

  // Flash only drives valid data while both CE and OE are asserted.
  assign dq = (!ce_n && !oe_n) ? word_at(faddr) : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: event times derived from the last reset edge and accepted loads.
  longint      cyc = 0;
  longint      rstn_rise = -1, ready_at = -1, ce_release = -1;
  bit          checking = 0;
  bit          in_access = 0;
  logic        exp_ready = 0, exp_ce_n = 1, exp_rstn = 0;
  logic [15:0] exp_data = 0, pend_data = 0;
  logic [22:0] exp_faddr = 0;

  always @(posedge clk) begin
    logic [15:0] w;
    cyc++;
    if (rst) begin
      checking   = 1;
      exp_ready  = 0;
      exp_ce_n   = 1;
      exp_rstn   = 0;
      exp_data   = 0;
      exp_faddr  = 0;
      in_access  = 0;
      rstn_rise  = cyc + RSTC;
      ready_at   = cyc + RSTC + REC;
      ce_release = -1;
    end else begin
      if (cyc == rstn_rise) exp_rstn = 1;
      if (cyc == ce_release) exp_ce_n = 1;
      if (exp_ready && load) begin
        w = word_at(addr[23:1]);
        if (byte_sel) pend_data = addr[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
        else pend_data = w;
        exp_faddr  = addr[23:1];
        exp_ready  = 0;
        exp_ce_n   = 0;
        in_access  = 1;
        ce_release = cyc + ACC + 1;
        ready_at   = cyc + ACC + 2;
      end else if (!exp_ready && cyc == ready_at) begin
        exp_ready = 1;
        if (in_access) exp_data = pend_data;
        in_access = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("ce_n", 32'(ce_n), 32'(exp_ce_n));
      chk("oe_n", 32'(oe_n), 32'(exp_ce_n));
      chk("flash_rst_n", 32'(frst_n), 32'(exp_rstn));
      chk("flash_addr", 32'(faddr), 32'(exp_faddr));
      chk("data", 32'(data), 32'(exp_data));
      chk("we_n", 32'(we_n), 32'd1);
      chk("byte_n", 32'(byte_n), 32'd1);
    end
  end

  // Called at the negedge right after the last rst edge; returns at the first ready cycle.
  task automatic reset_seq();
    int lo, rec;
    bit ce_seen;
    lo = 0;
    rec = 0;
    ce_seen = 0;
    addr = 24'h000040;
    while (frst_n === 1'b0 && lo < 200) begin
      if (!ce_n || !oe_n) ce_seen = 1;
      load = (lo >= 4 && lo < 7);
      lo++;
      @(negedge clk);
    end
    load = 0;
    while (ready !== 1'b1 && rec < 200) begin
      if (!ce_n || !oe_n) ce_seen = 1;
      rec++;
      @(negedge clk);
    end
    chk("rst_hold_len", 32'(lo), 32'(RSTC));
    chk("recov_len", 32'(rec), 32'(REC));
    chk("ce_oe_idle_in_reset", 32'(ce_seen), 32'd0);
  endtask

  task automatic do_read(input logic [23:0] a, input bit b, input logic [15:0] expd,
                         input logic [22:0] expa, input bit pulses);
    int lat, low;
    load = 1;
    addr = a;
    byte_sel = b;
    @(negedge clk);
    load = 0;
    if (pulses) addr = 24'h000300;
    chk("read_faddr", 32'(faddr), 32'(expa));
    lat = 0;
    low = 0;
    while (ready !== 1'b1 && lat < 100) begin
      if (!ce_n && !oe_n) low++;
      if (faddr !== expa) chk("faddr_stable", 32'(faddr), 32'(expa));
      load = pulses && (lat == 2 || lat == 4);
      @(negedge clk);
      lat++;
    end
    load = 0;
    chk("read_latency", 32'(lat), 32'(ACC + 2));
    chk("ce_low_cycles", 32'(low), 32'(ACC + 1));
    chk("read_data", 32'(data), 32'(expd));
  endtask

  initial begin
    rst = 1;
    load = 0;
    addr = 0;
    byte_sel = 0;
    mem[32'h82]  = 16'hBEEF;
    mem[32'h8]   = 16'h12AB;
    mem[32'h100] = 16'hC0DE;
    mem[32'h0]   = 16'h1111;
    mem[32'h1]   = 16'h2222;
    mem[32'h2]   = 16'h3333;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_faddr", 32'(faddr), 32'd0);
    chk("rst_ce_n", 32'(ce_n), 32'd1);
    chk("rst_flash_rst_n", 32'(frst_n), 32'd0);
    reset_seq();

    do_read(24'h000104, 1'b0, 16'hBEEF, 23'h000082, 1'b0);
    do_read(24'h000011, 1'b1, 16'h0012, 23'h000008, 1'b0);
    do_read(24'h000010, 1'b1, 16'h00AB, 23'h000008, 1'b0);
    do_read(24'h000105, 1'b0, 16'hBEEF, 23'h000082, 1'b0);
    do_read(24'h000200, 1'b0, 16'hC0DE, 23'h000100, 1'b1);

    // Reset sampled on the third edge into the access.
    load = 1;
    addr = 24'h000104;
    byte_sel = 0;
    @(negedge clk);
    load = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ce_n", 32'(ce_n), 32'd1);
    chk("abort_oe_n", 32'(oe_n), 32'd1);
    chk("abort_flash_rst_n", 32'(frst_n), 32'd0);
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_data", 32'(data), 32'd0);
    reset_seq();

    do_read(24'h000000, 1'b0, 16'h1111, 23'h000000, 1'b0);
    do_read(24'h000002, 1'b0, 16'h2222, 23'h000001, 1'b0);
    do_read(24'h000004, 1'b0, 16'h3333, 23'h000002, 1'b0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
